// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: operand/operation enums, trap codes and the ID/EX register layout.
package riscv_pkg;

    typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_lvl_e;
    typedef enum logic [1:0] {OPER1_RS1, OPER1_PC, OPER1_ZERO} alu_oper1_src_e;
    typedef enum logic [0:0] {OPER2_RS2, OPER2_IMM} alu_oper2_src_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_oper_e;
    typedef enum logic [3:0] {
        BNJ_NO, BNJ_JAL, BNJ_JALR, BNJ_BEQ, BNJ_BNE,
        BNJ_BLT, BNJ_BGE, BNJ_BLTU, BNJ_BGEU
    } bnj_oper_e;
    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_oper_e;
    typedef enum logic [1:0] {RESULT_ALU, RESULT_MEM, RESULT_PC4, RESULT_CSR} result_src_e;
    typedef enum logic [2:0] {
        NO_SYS, SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_WFI, ILLEGAL_INSTR
    } exc_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // All-zero value of this struct is the reset state of the ID/EX register.
    typedef struct packed {
        logic [31:0]    pc;
        logic [31:0]    rs1_data;
        logic [31:0]    rs2_data;
        logic [31:0]    imm;
        logic [31:0]    instr;
        alu_oper1_src_e alu_oper1_src;
        alu_oper2_src_e alu_oper2_src;
        alu_oper_e      alu_oper;
        bnj_oper_e      bnj_oper;
        mem_oper_e      mem_oper;
        result_src_e    result_src;
        exc_t           sys_instr;
        logic           write_rd;
        logic           csr_we;
        logic [4:0]     rd_addr;
        logic [4:0]     rs1_addr;
        logic [4:0]     rs2_addr;
    } id_ex_t;

    function automatic alu_oper_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: control fields of the ID/EX register plus illegal-instruction flag.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  priv_lvl_e   plvl_i,
    output id_ex_t      ctrl_o,
    output logic        csr_re_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign func3  = instr_i[14:12];
    assign func7  = instr_i[31:25];
    assign rd     = instr_i[11:7];
    assign rs1    = instr_i[19:15];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    id_ex_t c;
    logic   illegal;
    logic   csr_re;

    always_comb begin
        c          = '0;
        c.instr    = instr_i;
        c.rd_addr  = rd;
        c.rs1_addr = rs1;
        c.rs2_addr = instr_i[24:20];
        c.imm      = imm_i;
        illegal    = (instr_i[1:0] != 2'b11);
        csr_re     = 1'b0;

        case (opcode)
            OPC_LUI: begin
                c.alu_oper1_src = OPER1_ZERO;
                c.alu_oper2_src = OPER2_IMM;
                c.imm           = imm_u;
                c.write_rd      = 1'b1;
            end
            OPC_AUIPC: begin
                c.alu_oper1_src = OPER1_PC;
                c.alu_oper2_src = OPER2_IMM;
                c.imm           = imm_u;
                c.write_rd      = 1'b1;
            end
            OPC_JAL: begin
                c.alu_oper1_src = OPER1_PC;
                c.alu_oper2_src = OPER2_IMM;
                c.imm           = imm_j;
                c.bnj_oper      = BNJ_JAL;
                c.result_src    = RESULT_PC4;
                c.write_rd      = 1'b1;
            end
            OPC_JALR: begin
                c.alu_oper2_src = OPER2_IMM;
                c.bnj_oper      = BNJ_JALR;
                c.result_src    = RESULT_PC4;
                c.write_rd      = 1'b1;
                if (func3 != 3'b000) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                c.imm = imm_b;
                case (func3)
                    3'b000:  c.bnj_oper = BNJ_BEQ;
                    3'b001:  c.bnj_oper = BNJ_BNE;
                    3'b100:  c.bnj_oper = BNJ_BLT;
                    3'b101:  c.bnj_oper = BNJ_BGE;
                    3'b110:  c.bnj_oper = BNJ_BLTU;
                    3'b111:  c.bnj_oper = BNJ_BGEU;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.alu_oper2_src = OPER2_IMM;
                c.result_src    = RESULT_MEM;
                c.write_rd      = 1'b1;
                case (func3)
                    3'b000:  c.mem_oper = MEM_LB;
                    3'b001:  c.mem_oper = MEM_LH;
                    3'b010:  c.mem_oper = MEM_LW;
                    3'b100:  c.mem_oper = MEM_LBU;
                    3'b101:  c.mem_oper = MEM_LHU;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_STORE: begin
                c.alu_oper2_src = OPER2_IMM;
                c.imm           = imm_s;
                case (func3)
                    3'b000:  c.mem_oper = MEM_SB;
                    3'b001:  c.mem_oper = MEM_SH;
                    3'b010:  c.mem_oper = MEM_SW;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_ARITH: begin
                c.alu_oper = alu_from_f3(func3, func7[5]);
                c.write_rd = 1'b1;
                if (func7 != 7'h00 && func7 != 7'h20) illegal = 1'b1;
                if (func7 == 7'h20 && func3 != 3'b000 && func3 != 3'b101) illegal = 1'b1;
            end
            OPC_ARITH_IMM: begin
                c.alu_oper2_src = OPER2_IMM;
                c.alu_oper      = alu_from_f3(func3, (func3 == 3'b101) && func7[5]);
                c.write_rd      = 1'b1;
                if (func3 == 3'b001 && func7 != 7'h00) illegal = 1'b1;
                if (func3 == 3'b101 && func7 != 7'h00 && func7 != 7'h20) illegal = 1'b1;
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                if (func3 == 3'b000) begin
                    case (instr_i[31:20])
                        12'h000: c.sys_instr = SYS_ECALL;
                        12'h001: c.sys_instr = SYS_EBREAK;
                        12'h105: c.sys_instr = SYS_WFI;
                        12'h302: begin
                            c.sys_instr = SYS_MRET;
                            if (plvl_i != PRIV_M) illegal = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (func3 == 3'b100) begin
                    illegal = 1'b1;
                end else begin
                    // Set/clear with a zero source never modifies the CSR; write with rd=x0 never reads it.
                    c.result_src = RESULT_CSR;
                    c.write_rd   = 1'b1;
                    c.csr_we     = !(func3[1] && rs1 == 5'd0);
                    csr_re       = !(func3[1:0] == 2'b01 && rd == 5'd0);
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            c.sys_instr = ILLEGAL_INSTR;
            c.write_rd  = 1'b0;
            c.csr_we    = 1'b0;
            c.mem_oper  = MEM_NOP;
            c.bnj_oper  = BNJ_NO;
            csr_re      = 1'b0;
        end
    end

    assign ctrl_o    = c;
    assign csr_re_o  = csr_re;
    assign illegal_o = illegal;

endmodule

// File: rtl/decode_queue.sv
// Instruction FIFO between IF and EX: decodes the head (or the input on fall-through) into an ID/EX register.
module decode_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FALLTHROUGH = 1,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    input  logic           if_valid_i,
    output logic           if_ready_o,
    input  logic [31:0]    if_instr_i,
    input  logic [31:0]    if_pc_i,
    input  priv_lvl_e      current_plvl_i,
    output logic [4:0]     regf_rs1_addr_o,
    output logic [4:0]     regf_rs2_addr_o,
    input  logic [31:0]    rs1_data_i,
    input  logic [31:0]    rs2_data_i,
    output logic           csr_re_o,
    output logic           ex_valid_o,
    input  logic           ex_ready_i,
    output logic [31:0]    pc_o,
    output logic [31:0]    rs1_data_o,
    output logic [31:0]    rs2_data_o,
    output logic [31:0]    imm_o,
    output logic [31:0]    instr_o,
    output alu_oper1_src_e alu_oper1_src_o,
    output alu_oper2_src_e alu_oper2_src_o,
    output alu_oper_e      alu_oper_o,
    output bnj_oper_e      bnj_oper_o,
    output mem_oper_e      mem_oper_o,
    output result_src_e    result_src_o,
    output exc_t           sys_instr_o,
    output logic           write_rd_o,
    output logic           csr_we_o,
    output logic [4:0]     rd_addr_o,
    output logic [4:0]     rs1_addr_o,
    output logic [4:0]     rs2_addr_o,
    output logic [CNT_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      fifo_instr_q [DEPTH];
    logic [31:0]      fifo_pc_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             ex_valid_q, ex_valid_d;
    id_ex_t           ex_q, ex_d, load_data;

    logic        empty, can_load, fall_through, enq, deq, load;
    logic [31:0] sel_instr, sel_pc;
    id_ex_t      dec_ctrl;
    logic        dec_csr_re, dec_illegal;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (level_q == '0);
    assign if_ready_o   = (level_q < CNT_W'(DEPTH));
    assign can_load     = !ex_valid_q || ex_ready_i;
    assign fall_through = (FALLTHROUGH != 0) && empty && if_valid_i && can_load;
    assign enq          = if_valid_i && if_ready_o && !fall_through;
    assign deq          = !empty && can_load;
    assign load         = deq || fall_through;

    // Input is only a decode source while the queue is empty; otherwise the head is.
    assign sel_instr = empty ? (if_valid_i ? if_instr_i : '0) : fifo_instr_q[rd_ptr_q];
    assign sel_pc    = empty ? if_pc_i : fifo_pc_q[rd_ptr_q];

    assign regf_rs1_addr_o = sel_instr[19:15];
    assign regf_rs2_addr_o = sel_instr[24:20];

    instr_decoder u_dec (
        .instr_i   (sel_instr),
        .plvl_i    (current_plvl_i),
        .ctrl_o    (dec_ctrl),
        .csr_re_o  (dec_csr_re),
        .illegal_o (dec_illegal)
    );

    assign csr_re_o = load && !flush_i && dec_csr_re && !dec_illegal;

    always_comb begin
        load_data          = dec_ctrl;
        load_data.pc       = sel_pc;
        load_data.rs1_data = rs1_data_i;
        load_data.rs2_data = rs2_data_i;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ex_valid_d = 1'b0;
        end else begin
            if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
            level_d = level_q + CNT_W'(enq) - CNT_W'(deq);
            if (load) begin
                ex_valid_d = 1'b1;
                ex_d       = load_data;
            end else if (ex_ready_i) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            if (enq && !flush_i) begin
                fifo_instr_q[wr_ptr_q] <= if_instr_i;
                fifo_pc_q[wr_ptr_q]    <= if_pc_i;
            end
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign level_o         = level_q;
    assign pc_o            = ex_q.pc;
    assign rs1_data_o      = ex_q.rs1_data;
    assign rs2_data_o      = ex_q.rs2_data;
    assign imm_o           = ex_q.imm;
    assign instr_o         = ex_q.instr;
    assign alu_oper1_src_o = ex_q.alu_oper1_src;
    assign alu_oper2_src_o = ex_q.alu_oper2_src;
    assign alu_oper_o      = ex_q.alu_oper;
    assign bnj_oper_o      = ex_q.bnj_oper;
    assign mem_oper_o      = ex_q.mem_oper;
    assign result_src_o    = ex_q.result_src;
    assign sys_instr_o     = ex_q.sys_instr;
    assign write_rd_o      = ex_q.write_rd;
    assign csr_we_o        = ex_q.csr_we;
    assign rd_addr_o       = ex_q.rd_addr;
    assign rs1_addr_o      = ex_q.rs1_addr;
    assign rs2_addr_o      = ex_q.rs2_addr;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, FALLTHROUGH=1) with hand-computed expectations.
module tb_decode_queue;
    import riscv_pkg::*;

    logic           clk = 1'b0;
    logic           rst, flush, if_valid, ex_ready;
    logic [31:0]    if_instr, if_pc, rs1_data, rs2_data;
    priv_lvl_e      plvl;
    logic           if_ready, csr_re, ex_valid, write_rd, csr_we;
    logic [4:0]     regf_rs1, regf_rs2, rd_addr, rs1_addr, rs2_addr;
    logic [31:0]    pc, rs1_d, rs2_d, imm, instr;
    alu_oper1_src_e op1;
    alu_oper2_src_e op2;
    alu_oper_e      aluop;
    bnj_oper_e      bnj;
    mem_oper_e      mem;
    result_src_e    res;
    exc_t           sys;
    logic [2:0]     level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .FALLTHROUGH(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .current_plvl_i(plvl),
        .regf_rs1_addr_o(regf_rs1), .regf_rs2_addr_o(regf_rs2),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .csr_re_o(csr_re), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .pc_o(pc), .rs1_data_o(rs1_d), .rs2_data_o(rs2_d), .imm_o(imm), .instr_o(instr),
        .alu_oper1_src_o(op1), .alu_oper2_src_o(op2), .alu_oper_o(aluop),
        .bnj_oper_o(bnj), .mem_oper_o(mem), .result_src_o(res), .sys_instr_o(sys),
        .write_rd_o(write_rd), .csr_we_o(csr_we),
        .rd_addr_o(rd_addr), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .level_o(level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
        if_instr = '0; if_pc = '0; rs1_data = '0; rs2_data = '0; plvl = PRIV_M;
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_sys", 32'(sys), 32'(NO_SYS));
        rst = 1'b0;
        tick();
        chk("rel_if_ready", 32'(if_ready), 32'd1);

        // ADDI x1,x0,5 falls through the empty queue
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100; rs1_data = 32'hAAAA0000;
        #1;
        chk("ft_regf_rs1", 32'(regf_rs1), 32'd0);
        tick();
        if_valid = 1'b0;
        chk("ft_ex_valid", 32'(ex_valid), 32'd1);
        chk("ft_imm", imm, 32'd5);
        chk("ft_write_rd", 32'(write_rd), 32'd1);
        chk("ft_rd", 32'(rd_addr), 32'd1);
        chk("ft_op2", 32'(op2), 32'(OPER2_IMM));
        chk("ft_level", 32'(level), 32'd0);
        chk("ft_pc", pc, 32'h100);
        chk("ft_rs1_data", rs1_d, 32'hAAAA0000);

        // fill the queue while EX stalls
        if_valid = 1'b1;
        if_instr = 32'h00100113; if_pc = 32'h104; tick();
        if_instr = 32'h00200193; if_pc = 32'h108; tick();
        if_instr = 32'h0000000B; if_pc = 32'h10C; tick();
        if_instr = 32'h300022F3; if_pc = 32'h110; tick();
        chk("full_level", 32'(level), 32'd4);
        chk("full_if_ready", 32'(if_ready), 32'd0);
        chk("hold_ex_valid", 32'(ex_valid), 32'd1);
        chk("hold_imm", imm, 32'd5);
        chk("hold_pc", pc, 32'h100);
        if_instr = 32'h00700393; if_pc = 32'h114; tick();
        chk("full_no_enq", 32'(level), 32'd4);
        chk("hold_rd", 32'(rd_addr), 32'd1);
        if_valid = 1'b0; ex_ready = 1'b1;

        tick();
        chk("iss0_rd", 32'(rd_addr), 32'd2);
        chk("iss0_imm", imm, 32'd1);
        chk("iss0_pc", pc, 32'h104);
        chk("iss0_level", 32'(level), 32'd3);
        tick();
        chk("iss1_rd", 32'(rd_addr), 32'd3);
        chk("iss1_pc", pc, 32'h108);
        chk("iss1_level", 32'(level), 32'd2);
        tick();
        chk("ill_sys", 32'(sys), 32'(ILLEGAL_INSTR));
        chk("ill_write_rd", 32'(write_rd), 32'd0);
        chk("ill_mem", 32'(mem), 32'(MEM_NOP));
        chk("ill_instr", instr, 32'h0000000B);
        chk("ill_level", 32'(level), 32'd1);
        chk("csrrs_re", 32'(csr_re), 32'd1);
        tick();
        chk("csrrs_we", 32'(csr_we), 32'd0);
        chk("csrrs_rd", 32'(rd_addr), 32'd5);
        chk("csrrs_sys", 32'(sys), 32'(NO_SYS));
        chk("csrrs_pc", pc, 32'h110);
        chk("drain_level", 32'(level), 32'd0);

        // CSRRW x0,mstatus,x1 via fall-through
        if_valid = 1'b1; if_instr = 32'h30009073; if_pc = 32'h200; rs1_data = 32'h11223344;
        #1;
        chk("csrrw_re", 32'(csr_re), 32'd0);
        chk("csrrw_regf_rs1", 32'(regf_rs1), 32'd1);
        tick();
        chk("csrrw_we", 32'(csr_we), 32'd1);
        chk("csrrw_instr", instr, 32'h30009073);
        chk("csrrw_rs1_data", rs1_d, 32'h11223344);

        // JALR with func3=1 is illegal
        if_instr = 32'h00001067; if_pc = 32'h204;
        tick();
        if_valid = 1'b0;
        chk("jalr_sys", 32'(sys), 32'(ILLEGAL_INSTR));
        chk("jalr_bnj", 32'(bnj), 32'(BNJ_NO));
        tick();
        chk("drop_ex_valid", 32'(ex_valid), 32'd0);

        // flush with level 3 and a valid input in the flush cycle
        ex_ready = 1'b0; if_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_instr = 32'h00100113; if_pc = 32'h300 + 32'(4 * i);
            tick();
        end
        chk("pre_flush_level", 32'(level), 32'd3);
        flush = 1'b1; if_instr = 32'h00200193; if_pc = 32'h310;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        tick();
        chk("flush_no_issue", 32'(ex_valid), 32'd0);

        // reset mid-stream with level 2
        ex_ready = 1'b0; if_valid = 1'b1;
        if_instr = 32'h00812383; if_pc = 32'h400; tick();
        if_instr = 32'h00100113; if_pc = 32'h404; tick();
        if_instr = 32'h00200193; if_pc = 32'h408; tick();
        if_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd2);
        chk("pre_rst_mem", 32'(mem), 32'(MEM_LW));
        chk("pre_rst_imm", imm, 32'd8);
        rst = 1'b1;
        tick();
        chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_imm", imm, 32'd0);
        chk("mid_rst_rd", 32'(rd_addr), 32'd0);
        chk("mid_rst_mem", 32'(mem), 32'(MEM_NOP));
        chk("mid_rst_op2", 32'(op2), 32'(OPER2_RS2));
        chk("mid_rst_write_rd", 32'(write_rd), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_if_ready", 32'(if_ready), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
